// File: rtl/wu_trial_sequencer_if.sv
`default_nettype none
// ===================================================================
// wu_trial_sequencer_if : PC wire-in/wire-out bundle of the sequencer
// Revision: 1.0
// ===================================================================
interface wu_trial_sequencer_if #(
  parameter int CNT_W  = 20,
  parameter int TIME_W = 32
);
  logic              start;
  logic              abort;
  logic [CNT_W-1:0]  num_trials;
  logic [TIME_W-1:0] trig_period;
  logic [TIME_W-1:0] trig_width;
  logic [TIME_W-1:0] resp_window;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  trial_idx;
  logic [CNT_W-1:0]  tp_count;
  logic [CNT_W-1:0]  fp_count;
  logic [CNT_W-1:0]  missed_count;
  logic [TIME_W-1:0] last_latency;
  logic [TIME_W-1:0] max_latency;

  modport master (
    output start, abort, num_trials, trig_period, trig_width, resp_window,
    input  busy, done, trial_idx, tp_count, fp_count, missed_count,
           last_latency, max_latency
  );

  modport slave (
    input  start, abort, num_trials, trig_period, trig_width, resp_window,
    output busy, done, trial_idx, tp_count, fp_count, missed_count,
           last_latency, max_latency
  );
endinterface
`default_nettype wire

// File: rtl/wu_trial_sequencer.sv
`default_nettype none
// ===================================================================
// wu_trial_sequencer : runs N trigger/response trials and classifies
//                      wake-up edges as TP, FP or missed.
// Revision: 1.0
// ===================================================================
module wu_trial_sequencer #(
  parameter int CNT_W  = 20,
  parameter int TIME_W = 32
) (
  input  wire logic           clki,
  input  wire logic           reset,
  wu_trial_sequencer_if.slave ctl,
  input  wire logic           wake_up,
  output logic                trig_to_siggen
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              wk_s1, wk_s2, wk_q, start_q;
  logic              wk_edge, start_edge;
  logic [CNT_W-1:0]  n_trials, trial_idx, tp_cnt, fp_cnt, miss_cnt;
  logic [TIME_W-1:0] period, width, window, t, last_lat, max_lat;
  logic [TIME_W-1:0] period_san, width_lo, width_san, window_san, miss_t;
  logic              hit, trig, t_last, trial_last, tp_hit, miss_now;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    wk_edge    = wk_s2 & ~wk_q;
    start_edge = ctl.start & ~start_q;
    period_san = (ctl.trig_period < TIME_W'(2)) ? TIME_W'(2) : ctl.trig_period;
    width_lo   = (ctl.trig_width == '0) ? TIME_W'(1) : ctl.trig_width;
    width_san  = (width_lo > period_san - 1'b1) ? period_san - 1'b1 : width_lo;
    window_san = (ctl.resp_window > period_san) ? period_san : ctl.resp_window;
    // A full-period window has no cycle t==window, so the miss is judged on the last cycle.
    miss_t     = (window == period) ? period - 1'b1 : window;
    t_last     = (t == period - 1'b1);
    trial_last = ((trial_idx + 1'b1) == n_trials);
    tp_hit     = wk_edge && (t < window) && !hit;
    miss_now   = (t == miss_t) && !hit && !tp_hit;
  end

  always_comb begin
    state_nxt = state;
    if (ctl.abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (start_edge) state_nxt = (ctl.num_trials == '0) ? DONE : RUN;
        RUN:        if (t_last && trial_last) state_nxt = DONE;
        default:    state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clki) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clki) begin
    if (!reset) begin
      wk_s1     <= 1'b0;
      wk_s2     <= 1'b0;
      wk_q      <= 1'b0;
      start_q   <= 1'b0;
      n_trials  <= '0;
      period    <= '0;
      width     <= '0;
      window    <= '0;
      t         <= '0;
      hit       <= 1'b0;
      trig      <= 1'b0;
      trial_idx <= '0;
      tp_cnt    <= '0;
      fp_cnt    <= '0;
      miss_cnt  <= '0;
      last_lat  <= '0;
      max_lat   <= '0;
    end else begin
      wk_s1   <= wake_up;
      wk_s2   <= wk_s1;
      wk_q    <= wk_s2;
      start_q <= ctl.start;
      if (ctl.abort) begin
        trig <= 1'b0;
      end else if (state != RUN) begin
        trig <= 1'b0;
        if (start_edge) begin
          n_trials  <= ctl.num_trials;
          period    <= period_san;
          width     <= width_san;
          window    <= window_san;
          t         <= '0;
          hit       <= 1'b0;
          trial_idx <= '0;
          tp_cnt    <= '0;
          fp_cnt    <= '0;
          miss_cnt  <= '0;
          last_lat  <= '0;
          max_lat   <= '0;
          trig      <= (ctl.num_trials != '0);
        end
      end else begin
        if (tp_hit) begin
          tp_cnt   <= sat_inc(tp_cnt);
          last_lat <= t;
          if (t > max_lat) max_lat <= t;
          hit      <= 1'b1;
        end else if (wk_edge) begin
          fp_cnt <= sat_inc(fp_cnt);
        end
        if (miss_now) miss_cnt <= sat_inc(miss_cnt);
        // Trial wrap comes last so its hit clear wins over a TP on the final cycle.
        if (t_last) begin
          t         <= '0;
          hit       <= 1'b0;
          trial_idx <= trial_idx + 1'b1;
          trig      <= !trial_last;
        end else begin
          t    <= t + 1'b1;
          trig <= ((t + 1'b1) < width);
        end
      end
    end
  end

  assign trig_to_siggen   = trig;
  assign ctl.busy         = (state == RUN);
  assign ctl.done         = (state == DONE);
  assign ctl.trial_idx    = trial_idx;
  assign ctl.tp_count     = tp_cnt;
  assign ctl.fp_count     = fp_cnt;
  assign ctl.missed_count = miss_cnt;
  assign ctl.last_latency = last_lat;
  assign ctl.max_latency  = max_lat;

endmodule
`default_nettype wire
